// File: rtl/mac_vec_engine.sv
// mac_vec_engine: sequential 4-lane dot-product engine with a handshaked vector
// input and a valid/ready partial-sum output. One MAC lane is processed per cycle.
module mac_vec_engine #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned lanes   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [bw*lanes-1:0]   x_vec,
    input  logic [bw*lanes-1:0]   w_vec,
    input  logic                  in_first,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [psum_bw-1:0]    out,
    output logic                  busy
);

    localparam int unsigned VW = bw * lanes;
    localparam int unsigned CW = (lanes > 1) ? $clog2(lanes) : 1;
    localparam int unsigned PW = 2 * bw + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [CW-1:0] LAST_LANE = CW'(lanes - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [VW-1:0]      x_q, x_d;
    logic [VW-1:0]      w_q, w_d;
    logic [psum_bw-1:0] acc_q, acc_d;
    logic               in_ready_q, out_valid_q, busy_q;
    logic               in_ready_d, out_valid_d, busy_d;

    logic [bw-1:0]         x_lane [lanes];
    logic [bw-1:0]         w_lane [lanes];
    logic signed [PW-1:0]  x_ext;
    logic signed [PW-1:0]  w_ext;
    logic signed [PW-1:0]  prod;
    logic [psum_bw-1:0]    prod_ext;

    // Split latched vectors into per-lane elements
    always_comb begin
        for (int i = 0; i < int'(lanes); i++) begin
            x_lane[i] = x_q[bw*i +: bw];
            w_lane[i] = w_q[bw*i +: bw];
        end
    end

    // Lane product: x zero-extended, w sign-extended, result sign-extended to psum width
    always_comb begin
        x_ext    = PW'($signed({1'b0, x_lane[cnt_q]}));
        w_ext    = PW'($signed(w_lane[cnt_q]));
        prod     = x_ext * w_ext;
        prod_ext = psum_bw'(prod);
    end

    // Next-state, datapath and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        w_d     = w_q;
        acc_d   = acc_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = x_vec;
                    w_d     = w_vec;
                    cnt_d   = '0;
                    state_d = S_COMPUTE;
                    if (in_first) begin
                        acc_d = '0;
                    end
                end
            end
            S_COMPUTE: begin
                acc_d = acc_q + prod_ext;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_LANE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_COMPUTE) || (state_d == S_DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            w_q         <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            w_q         <= w_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out       = acc_q;

endmodule

// File: tb/tb_mac_vec_engine.sv
// tb_mac_vec_engine: directed and randomized checks of mac_vec_engine against
// an arithmetic dot-product reference model.
module tb_mac_vec_engine;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_vec;
    logic [15:0] w_vec;
    logic        in_first;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        busy;

    int checks;
    int failures;
    int model_acc;

    mac_vec_engine dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_vec     (x_vec),
        .w_vec     (w_vec),
        .in_first  (in_first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pack4(input int a0, input int a1, input int a2, input int a3);
        logic [3:0] e0, e1, e2, e3;
        e0 = 4'(a0); e1 = 4'(a1); e2 = 4'(a2); e3 = 4'(a3);
        return {e3, e2, e1, e0};
    endfunction

    // Reference: plain integer dot product of unsigned x and signed w
    function automatic int dot4(input logic [15:0] xv, input logic [15:0] wv);
        int s;
        logic [3:0]        xs;
        logic signed [3:0] ws;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            xs = xv[4*i +: 4];
            ws = wv[4*i +: 4];
            s  = s + int'(xs) * int'(ws);
        end
        return s;
    endfunction

    // Send one vector, check latency, backpressure hold and result, then drain
    task automatic run_vec(input logic [15:0] xv, input logic [15:0] wv,
                           input logic first, input int hold, input bit check_all);
        int n;
        int lat;
        logic [15:0] exp;
        if (first) model_acc = 0;
        model_acc = (model_acc + dot4(xv, wv)) & 32'hFFFF;
        exp = 16'(model_acc);

        @(negedge clk);
        in_valid = 1'b1; x_vec = xv; w_vec = wv; in_first = first; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (check_all) begin
            check_eq("busy_after_accept", 32'(busy), 32'd1);
            check_eq("in_ready_after_accept", 32'(in_ready), 32'd0);
        end
        lat = 0;
        while (!out_valid && lat < 50) begin
            in_valid = 1'($urandom); x_vec = 16'($urandom); w_vec = 16'($urandom);
            in_first = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        if (check_all) check_eq("latency", 32'(lat), 32'd4);
        check_eq("result", 32'(out), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom); x_vec = 16'($urandom); w_vec = 16'($urandom);
            in_first = 1'($urandom);
            @(negedge clk);
            check_eq("hold_out", 32'(out), 32'(exp));
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
            check_eq("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        if (check_all) begin
            check_eq("post_in_ready", 32'(in_ready), 32'd1);
            check_eq("post_out_valid", 32'(out_valid), 32'd0);
            check_eq("post_out_kept", 32'(out), 32'(exp));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] xa, wa;
        checks = 0; failures = 0; model_acc = 0;
        reset_n = 1'b0; in_valid = 1'b0; x_vec = '0; w_vec = '0;
        in_first = 1'b0; out_ready = 1'b0;
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out", 32'(out), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic dot product: -3
        run_vec(pack4(1, 2, 3, 4), pack4(1, -1, 2, -2), 1'b1, 0, 1'b1);
        check_eq("basic_value", 32'(out), 32'h0000FFFD);

        // Extremes
        run_vec(pack4(15, 15, 15, 15), pack4(-8, -8, -8, -8), 1'b1, 1, 1'b1);
        check_eq("extreme_neg", 32'(out), 32'h0000FE20);
        run_vec(pack4(15, 15, 15, 15), pack4(7, 7, 7, 7), 1'b1, 0, 1'b1);
        check_eq("extreme_pos", 32'(out), 32'h000001A4);

        // Accumulation across vectors
        run_vec(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 1'b1, 0, 1'b1);
        check_eq("accum_a", 32'(out), 32'h0000000A);
        run_vec(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 1'b0, 0, 1'b1);
        check_eq("accum_b", 32'(out), 32'h00000014);
        run_vec(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 1'b1, 0, 1'b1);
        check_eq("accum_c", 32'(out), 32'h0000000A);

        // Wrap-around over 157 vectors
        for (int v = 0; v < 157; v++) begin
            run_vec(pack4(15, 15, 15, 15), pack4(7, 7, 7, 7), (v == 0), 0, 1'b0);
        end
        check_eq("wrap_value", 32'(out), 32'h00000194);

        // Backpressure with garbage inputs during COMPUTE/DONE
        run_vec(pack4(3, 5, 7, 9), pack4(2, -3, 4, -5), 1'b1, 5, 1'b1);

        // Randomized vectors
        for (int r = 0; r < 40; r++) begin
            xa = 16'($urandom); wa = 16'($urandom);
            run_vec(xa, wa, 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), 1'b1);
        end

        // Reset mid-COMPUTE
        @(negedge clk);
        in_valid = 1'b1; x_vec = pack4(9, 9, 9, 9); w_vec = pack4(3, 3, 3, 3); in_first = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_out", 32'(out), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        model_acc = 0;
        @(negedge clk);
        reset_n = 1'b1;
        run_vec(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b0, 0, 1'b1);
        check_eq("after_rst_value", 32'(out), 32'h00000004);

        // Reset in DONE
        @(negedge clk);
        in_valid = 1'b1; x_vec = pack4(2, 2, 2, 2); w_vec = pack4(2, 2, 2, 2); in_first = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("done_before_rst", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("donerst_out_valid", 32'(out_valid), 32'd0);
        check_eq("donerst_out", 32'(out), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
